// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO (sync_fifo).
package sync_fifo_pkg;

    localparam int DEF_DSIZE = 8;
    localparam int DEF_ASIZE = 4;
    localparam int DEPTH     = 2 ** DEF_ASIZE;

    // Pointer carries one extra wrap bit above the memory address.
    typedef logic [DEF_ASIZE:0] ptr_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: synchronous write port, asynchronous read port.
module sync_fifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem_r [0:(2**ASIZE)-1];

    // Write port; contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock fall-through FIFO with fifo1-compatible ports.
// Optional sticky overflow/underflow flags when SYNC_FIFO_ERR_EN is defined.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int ASIZE = DEF_ASIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic             woverflow,
    output logic             runderflow
`endif
);

    localparam logic [ASIZE:0] PTR_ZERO = {(ASIZE+1){1'b0}};
    localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};

    logic [ASIZE:0] wptr_r;
    logic [ASIZE:0] rptr_r;
    logic           wen_s;
    logic           ren_s;

    // Full when the addresses match but the wrap bits differ.
    assign rempty = (wptr_r == rptr_r);
    assign wfull  = (wptr_r[ASIZE] != rptr_r[ASIZE]) &&
                    (wptr_r[ASIZE-1:0] == rptr_r[ASIZE-1:0]);

    assign wen_s = winc && !wfull;
    assign ren_s = rinc && !rempty;

    // Pointer update; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= PTR_ZERO;
            rptr_r <= PTR_ZERO;
        end else begin
            if (wen_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (ren_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .wen   (wen_s),
        .waddr (wptr_r[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr_r[ASIZE-1:0]),
        .rdata (rdata)
    );

`ifdef SYNC_FIFO_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            woverflow  <= 1'b0;
            runderflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model, directed and random stimulus.
module tb_sync_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic [7:0] wdata;
    logic       wfull;
    logic       rinc;
    logic [7:0] rdata;
    logic       rempty;
`ifdef SYNC_FIFO_ERR_EN
    logic       woverflow;
    logic       runderflow;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk    (clk),
        .rst    (rst),
        .winc   (winc),
        .wdata  (wdata),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .woverflow  (woverflow),
        .runderflow (runderflow)
`endif
    );

    // One clock edge; the model applies the FIFO rules to its pre-edge occupancy.
    task automatic tick();
        bit wacc;
        bit racc;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wacc = winc && (q.size() < DEPTH);
            racc = rinc && (q.size() > 0);
            if (winc && q.size() == DEPTH) m_ovf = 1'b1;
            if (rinc && q.size() == 0) m_unf = 1'b1;
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(wdata);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rempty !== 1'b1 || wfull !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: rempty=%b wfull=%b, expected rempty=1 wfull=0", rempty, wfull);
        end
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        checks++;
        if (rempty !== 1'b1) begin
            errors++;
            $display("FAIL read_empty: rempty=%b, expected 1", rempty);
        end
        winc = 1'b1; wdata = 8'h3C;
        tick();
        winc = 1'b0;
        checks++;
        if (rempty !== 1'b0 || rdata !== 8'h3C) begin
            errors++;
            $display("FAIL read_empty_no_move: rempty=%b rdata=%h, expected rempty=0 rdata=3c", rempty, rdata);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            winc = 1'b1; wdata = 8'(i);
            tick();
            checks++;
            if (wfull !== (i == DEPTH - 1) || rempty !== 1'b0 || rdata !== 8'h00) begin
                errors++;
                $display("FAIL fill_%0d: wfull=%b rempty=%b rdata=%h, expected wfull=%b rempty=0 rdata=00",
                         i, wfull, rempty, rdata, (i == DEPTH - 1));
            end
        end
        wdata = 8'hAA;
        tick();
        winc = 1'b0;
        checks++;
        if (wfull !== 1'b1 || q.size() != DEPTH) begin
            errors++;
            $display("FAIL overfill: wfull=%b, expected 1", wfull);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (rempty !== 1'b0 || rdata !== 8'(i)) begin
                errors++;
                $display("FAIL drain_%0d: rempty=%b rdata=%h, expected rempty=0 rdata=%h", i, rempty, rdata, 8'(i));
            end
            rinc = 1'b1;
            tick();
        end
        rinc = 1'b0;
        checks++;
        if (rempty !== 1'b1 || wfull !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: rempty=%b wfull=%b, expected rempty=1 wfull=0", rempty, wfull);
        end
    endtask

    task automatic test_simul_full();
        int n;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            winc = 1'b1; wdata = 8'(i);
            tick();
        end
        winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
        tick();
        winc = 1'b0; rinc = 1'b0;
        checks++;
        if (wfull !== 1'b0 || rempty !== 1'b0 || rdata !== 8'h01) begin
            errors++;
            $display("FAIL simul_full: wfull=%b rempty=%b rdata=%h, expected wfull=0 rempty=0 rdata=01", wfull, rempty, rdata);
        end
        n = 0;
        while (rempty === 1'b0 && n < 20) begin
            checks++;
            if (rdata !== q[0]) begin
                errors++;
                $display("FAIL simul_drain_%0d: rdata=%h, expected %h", n, rdata, q[0]);
            end
            rinc = 1'b1;
            tick();
            n++;
        end
        rinc = 1'b0;
        checks++;
        if (n != DEPTH - 1) begin
            errors++;
            $display("FAIL simul_count: read %0d words, expected %0d", n, DEPTH - 1);
        end
    endtask

    task automatic test_stream();
        do_reset();
        winc = 1'b1; wdata = 8'h55;
        tick();
        rinc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wdata = 8'($urandom);
            tick();
            checks++;
            if (rempty !== 1'b0 || wfull !== 1'b0 || q.size() != 1 || rdata !== q[0]) begin
                errors++;
                $display("FAIL stream_%0d: rempty=%b wfull=%b rdata=%h, expected rempty=0 wfull=0 rdata=%h",
                         i, rempty, wfull, rdata, q[0]);
            end
        end
        winc = 1'b0;
        tick();
        rinc = 1'b0;
        checks++;
        if (rempty !== 1'b1) begin
            errors++;
            $display("FAIL stream_end: rempty=%b, expected 1", rempty);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            winc  = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 70 : 35));
            rinc  = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 35 : 70));
            wdata = 8'($urandom);
            tick();
            exp_d = (q.size() > 0) ? q[0] : rdata;
            checks++;
            if (rempty !== (q.size() == 0) || wfull !== (q.size() == DEPTH) || rdata !== exp_d) begin
                errors++;
                $display("FAIL random_%0d: rempty=%b wfull=%b rdata=%h, expected rempty=%b wfull=%b rdata=%h",
                         i, rempty, wfull, rdata, (q.size() == 0), (q.size() == DEPTH), exp_d);
            end
`ifdef SYNC_FIFO_ERR_EN
            checks++;
            if (woverflow !== m_ovf || runderflow !== m_unf) begin
                errors++;
                $display("FAIL random_err_%0d: woverflow=%b runderflow=%b, expected %b %b",
                         i, woverflow, runderflow, m_ovf, m_unf);
            end
`endif
        end
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    endtask

`ifdef SYNC_FIFO_ERR_EN
    task automatic test_err();
        do_reset();
        checks++;
        if (woverflow !== 1'b0 || runderflow !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: woverflow=%b runderflow=%b, expected 0 0", woverflow, runderflow);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            winc = 1'b1; wdata = 8'(i);
            tick();
        end
        winc = 1'b0;
        checks++;
        if (woverflow !== 1'b1 || runderflow !== 1'b0) begin
            errors++;
            $display("FAIL err_ovf: woverflow=%b runderflow=%b, expected 1 0", woverflow, runderflow);
        end
        for (int i = 0; i <= DEPTH; i++) begin
            rinc = 1'b1;
            tick();
        end
        rinc = 1'b0;
        checks++;
        if (woverflow !== 1'b1 || runderflow !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: woverflow=%b runderflow=%b, expected 1 1", woverflow, runderflow);
        end
        do_reset();
        checks++;
        if (woverflow !== 1'b0 || runderflow !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: woverflow=%b runderflow=%b, expected 0 0", woverflow, runderflow);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_simul_full();
        test_stream();
        test_random();
`ifdef SYNC_FIFO_ERR_EN
        test_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
